// File: rtl/ram_cache_pkg.sv
// rtl/ram_cache_pkg.sv - shared types and address-field widths for ram_cache
package ram_cache_pkg;

  localparam int ADDR_BITS      = 25;
  localparam int DATA_BITS      = 32;
  localparam int INDEX_BITS_DEF = 8;

  // The tag is whatever word-address bits the index does not cover.
  function automatic int tag_bits(input int index_bits);
    return ADDR_BITS - index_bits;
  endfunction

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/ram_cache_store.sv
// rtl/ram_cache_store.sv - tag/valid/data line array, registered read address, one write port plus clear
module ram_cache_store
  import ram_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = tag_bits(INDEX_BITS)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_BITS-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  clr_en,
  input  logic [INDEX_BITS-1:0] clr_index
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [DATA_BITS-1:0] data_mem [LINES];
  logic [INDEX_BITS-1:0] rd_index_q;

  always_ff @(posedge clk) begin
    if (rd_en) rd_index_q <= rd_index;
  end

  // Clear wins over write; the two are never requested together by the controller.
  always_ff @(posedge clk) begin
    if (clr_en)     valid_q[clr_index] <= 1'b0;
    else if (wr_en) valid_q[wr_index]  <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index_q];
  assign rd_tag   = tag_mem[rd_index_q];
  assign rd_data  = data_mem[rd_index_q];

endmodule

// File: rtl/ram_cache.sv
// rtl/ram_cache.sv - direct-mapped write-through write-allocate one-word-line cache in front of ram
module ram_cache
  import ram_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stb,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ack,
  output logic                 mem_stb,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  input  logic [DATA_BITS-1:0] mem_dout,
  input  logic                 mem_ack
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS);

  state_t state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  req_addr_q, req_addr_d;
  logic                  req_we_q, req_we_d;
  logic [DATA_BITS-1:0]  req_data_q, req_data_d;
  logic [DATA_BITS-1:0]  data_out_d, mem_din_d;
  logic [ADDR_BITS-1:0]  mem_addr_d;
  logic                  ack_d, mem_stb_d, mem_we_d;

  logic                  rd_en, rd_valid, wr_en, clr_en, hit;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_BITS-1:0]  rd_data, wr_data;

  ram_cache_store #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_store (
    .clk      (clk),
    .rd_en    (rd_en),
    .rd_index (addr[INDEX_BITS-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (req_addr_q[INDEX_BITS-1:0]),
    .wr_tag   (req_addr_q[ADDR_BITS-1:INDEX_BITS]),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_index(cnt_q)
  );

  assign hit = rd_valid && (rd_tag == req_addr_q[ADDR_BITS-1:INDEX_BITS]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_we_d   = req_we_q;
    req_data_d = req_data_q;
    data_out_d = data_out;
    mem_stb_d  = mem_stb;
    mem_we_d   = mem_we;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    ack_d      = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    clr_en     = 1'b0;
    wr_data    = req_data_q;
    case (state_q)
      INIT: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (stb) begin
          req_addr_d = addr;
          req_we_d   = we;
          req_data_d = data_in;
          rd_en      = 1'b1;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_we_q) begin
          // Allocate on write regardless of hit; memory is always written too.
          wr_en      = 1'b1;
          mem_stb_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = req_addr_q;
          mem_din_d  = req_data_q;
          state_d    = WRITE;
        end else if (hit) begin
          ack_d      = 1'b1;
          data_out_d = rd_data;
          state_d    = DONE;
        end else begin
          mem_stb_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr_q;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          wr_en      = 1'b1;
          wr_data    = mem_dout;
          data_out_d = mem_dout;
          mem_stb_d  = 1'b0;
          ack_d      = 1'b1;
          state_d    = DONE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          mem_stb_d = 1'b0;
          mem_we_d  = 1'b0;
          ack_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_we_q   <= 1'b0;
      req_data_q <= '0;
      ack        <= 1'b0;
      data_out   <= '0;
      mem_stb    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_we_q   <= req_we_d;
      req_data_q <= req_data_d;
      ack        <= ack_d;
      data_out   <= data_out_d;
      mem_stb    <= mem_stb_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
    end
  end

endmodule
